// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl
// Central stall/flush sequencer for the 5-stage RISC-V pipeline.
//
// It handles three kinds of hazard: load-use hazards that forwarding cannot
// cover, branch/jump redirects resolved in EX, and instruction/data memory
// wait states. It also keeps a saturating stall performance counter and a
// sticky data-memory timeout flag.
//
// Parameters:
//   MEM_TIMEOUT - consecutive dmem wait cycles before timeout_err sets (1..255)
//   CNT_W       - width of stall_cnt
//
// Ports:
//   clk, rst_n            - pipeline clock, asynchronous active-low reset
//   ID_EX_MemRd           - the instruction in EX is a load
//   ID_EX_rd_idx          - destination register of the EX instruction
//   IF_ID_rs1_idx/rs2_idx - source registers of the ID instruction
//   IF_ID_use_rs2         - the ID instruction reads rs2
//   EX_branch_taken       - a branch/jump in EX redirects the PC
//   dmem_req, dmem_ready  - MEM stage request and completion handshake
//   imem_ready            - instruction fetch returns valid data this cycle
//   perf_clr              - synchronous clear of stall_cnt
//   pc_stall ... MEM_WB_flush - per-stage stall/flush controls (combinational)
//   hazard_state          - current FSM state (RUN/LDUSE/MEMWAIT/REDIRECT)
//   stall_cnt             - number of cycles with pc_stall=1, saturating
//   timeout_err           - sticky dmem timeout flag

module riscv_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_EX_MemRd,
    input  logic [4:0]       ID_EX_rd_idx,
    input  logic [4:0]       IF_ID_rs1_idx,
    input  logic [4:0]       IF_ID_rs2_idx,
    input  logic             IF_ID_use_rs2,
    input  logic             EX_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    input  logic             perf_clr,
    output logic             pc_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_stall,
    output logic             ID_EX_flush,
    output logic             EX_MEM_stall,
    output logic             MEM_WB_flush,
    output logic [1:0]       hazard_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LDUSE    = 2'd1,
        ST_MEMWAIT  = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    localparam logic [7:0]       TIMEOUT_LIM = 8'(MEM_TIMEOUT);
    localparam logic [7:0]       WAIT_ONE    = 8'd1;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_wait;
    logic load_use;

    // A pending memory access that has not completed yet freezes the whole pipe.
    assign mem_wait = dmem_req & ~dmem_ready;

    // Register x0 is hard-wired to zero, so a load into it is never a hazard.
    assign load_use = ID_EX_MemRd & (ID_EX_rd_idx != 5'd0) &
                      ((ID_EX_rd_idx == IF_ID_rs1_idx) |
                       (IF_ID_use_rs2 & (ID_EX_rd_idx == IF_ID_rs2_idx)));

    // Prioritised control decode. Leaving LDUSE or MEMWAIT behaves exactly like
    // RUN. Only REDIRECT changes the decode, because it keeps waiting for the
    // fetch at the branch target.
    always_comb begin
        pc_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_stall  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_stall = 1'b0;
        MEM_WB_flush = 1'b0;
        state_d      = ST_RUN;

        if (mem_wait) begin
            // EX is frozen as well, so a taken branch waits here and is
            // serviced on the first cycle after the access completes.
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_flush = 1'b1;
            state_d      = ST_MEMWAIT;
        end else if (EX_branch_taken) begin
            // The PC loads the target. The two wrong-path instructions are
            // flushed, and this overrides any load-use stall in the same cycle.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            state_d     = ST_REDIRECT;
        end else if (state_q == ST_REDIRECT) begin
            if (!imem_ready) begin
                pc_stall    = 1'b1;
                IF_ID_flush = 1'b1;
                state_d     = ST_REDIRECT;
            end
        end else if (load_use) begin
            pc_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_EX_flush = 1'b1;
            state_d     = ST_LDUSE;
        end else if (!imem_ready) begin
            pc_stall    = 1'b1;
            IF_ID_flush = 1'b1;
        end

        // Every control is quiet while reset is held.
        if (!rst_n) begin
            pc_stall     = 1'b0;
            IF_ID_stall  = 1'b0;
            IF_ID_flush  = 1'b0;
            ID_EX_stall  = 1'b0;
            ID_EX_flush  = 1'b0;
            EX_MEM_stall = 1'b0;
            MEM_WB_flush = 1'b0;
        end
    end

    // Wait counter, timeout flag and stall counter next-state logic.
    always_comb begin
        wait_cnt_d = 8'd0;
        if (mem_wait) begin
            wait_cnt_d = (wait_cnt_q < TIMEOUT_LIM) ? (wait_cnt_q + WAIT_ONE)
                                                    : wait_cnt_q;
        end

        // Sticky flag. It sets on the edge where the counter reaches the limit.
        timeout_err_d = timeout_err_q | (mem_wait & (wait_cnt_d == TIMEOUT_LIM));

        // A clear request takes precedence over counting a stall cycle.
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
        end else if (pc_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            timeout_err_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign hazard_state = state_q;
    assign stall_cnt    = stall_cnt_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// tb_riscv_hazard_ctrl
// Bench for riscv_hazard_ctrl, built with CNT_W=4 and MEM_TIMEOUT=16.
// Each cycle the driver computes the expected outputs from a small reference
// model and queues them. A monitor pops the queue and compares the values
// a little after the falling edge.

module tb_riscv_hazard_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_SAT     = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             ID_EX_MemRd;
    logic [4:0]       ID_EX_rd_idx;
    logic [4:0]       IF_ID_rs1_idx;
    logic [4:0]       IF_ID_rs2_idx;
    logic             IF_ID_use_rs2;
    logic             EX_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             imem_ready;
    logic             perf_clr;
    logic             pc_stall;
    logic             IF_ID_stall;
    logic             IF_ID_flush;
    logic             ID_EX_stall;
    logic             ID_EX_flush;
    logic             EX_MEM_stall;
    logic             MEM_WB_flush;
    logic [1:0]       hazard_state;
    logic [CNT_W-1:0] stall_cnt;
    logic             timeout_err;

    // Each expected vector is {7 controls, hazard_state, stall_cnt, timeout_err}.
    // The controls are ordered pc, ifid_stall, ifid_flush, idex_stall,
    // idex_flush, exmem_stall, memwb_flush.
    logic [13:0] expQ[$];
    string       tagQ[$];

    int vecCount  = 0;
    int missCount = 0;

    // Reference model state: the values the DUT registers should hold right now.
    int mState = 0;
    int mWait  = 0;
    int mCnt   = 0;
    bit mErr   = 1'b0;

    riscv_hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ID_EX_MemRd    (ID_EX_MemRd),
        .ID_EX_rd_idx   (ID_EX_rd_idx),
        .IF_ID_rs1_idx  (IF_ID_rs1_idx),
        .IF_ID_rs2_idx  (IF_ID_rs2_idx),
        .IF_ID_use_rs2  (IF_ID_use_rs2),
        .EX_branch_taken(EX_branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .imem_ready     (imem_ready),
        .perf_clr       (perf_clr),
        .pc_stall       (pc_stall),
        .IF_ID_stall    (IF_ID_stall),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_stall    (ID_EX_stall),
        .ID_EX_flush    (ID_EX_flush),
        .EX_MEM_stall   (EX_MEM_stall),
        .MEM_WB_flush   (MEM_WB_flush),
        .hazard_state   (hazard_state),
        .stall_cnt      (stall_cnt),
        .timeout_err    (timeout_err)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point. It counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [13:0] observed,
                               input logic [13:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got ctrl=%b st=%0d cnt=%0d err=%b, expected ctrl=%b st=%0d cnt=%0d err=%b",
                     tag, observed[13:7], observed[6:5], observed[4:1], observed[0],
                     expected[13:7], expected[6:5], expected[4:1], expected[0]);
        end
    endtask

    // Drives one cycle of inputs on the falling edge and queues the expected
    // outputs. Then it advances the reference model to the state after the
    // next rising edge.
    task automatic applyStimulus(input string tag, input logic rstn,
                                 input logic memRd, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic useRs2, input logic branch,
                                 input logic dReq, input logic dRdy,
                                 input logic iRdy, input logic pClr);
        logic       mw;
        logic       lu;
        logic [6:0] ctrl;
        int         nState;
        @(negedge clk);
        rst_n           = rstn;
        ID_EX_MemRd     = memRd;
        ID_EX_rd_idx    = rd;
        IF_ID_rs1_idx   = rs1;
        IF_ID_rs2_idx   = rs2;
        IF_ID_use_rs2   = useRs2;
        EX_branch_taken = branch;
        dmem_req        = dReq;
        dmem_ready      = dRdy;
        imem_ready      = iRdy;
        perf_clr        = pClr;

        if (!rstn) begin
            mState = 0;
            mWait  = 0;
            mCnt   = 0;
            mErr   = 1'b0;
        end

        mw     = dReq & ~dRdy;
        lu     = memRd && (rd != 5'd0) && ((rd == rs1) || (useRs2 && (rd == rs2)));
        ctrl   = 7'b0000000;
        nState = 0;
        if (!rstn) begin
            ctrl = 7'b0000000;
        end else if (mw) begin
            ctrl   = 7'b1101011;
            nState = 2;
        end else if (branch) begin
            ctrl   = 7'b0010100;
            nState = 3;
        end else if (mState == 3) begin
            if (!iRdy) begin
                ctrl   = 7'b1010000;
                nState = 3;
            end
        end else if (lu) begin
            ctrl   = 7'b1100100;
            nState = 1;
        end else if (!iRdy) begin
            ctrl = 7'b1010000;
        end

        expQ.push_back({ctrl, 2'(mState), 4'(mCnt), mErr});
        tagQ.push_back(tag);

        if (rstn) begin
            if (mw) begin
                if (mWait < MEM_TIMEOUT) mWait++;
                if (mWait == MEM_TIMEOUT) mErr = 1'b1;
            end else begin
                mWait = 0;
            end
            if (pClr) mCnt = 0;
            else if (ctrl[6] && (mCnt < CNT_SAT)) mCnt++;
            mState = nState;
        end
    endtask

    // Quiet pipeline: no hazards and fetch always ready.
    task automatic idleCycles(input string tag, input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Data memory busy for n cycles, with the branch input optionally held.
    task automatic memWaitCycles(input string tag, input int n, input logic branch);
        for (int i = 0; i < n; i++)
            applyStimulus(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, branch, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: it samples two time units after each falling edge, well away
    // from the rising edge, and compares against the oldest queued expectation.
    always @(negedge clk) begin : monitor
        logic [13:0] e;
        string       t;
        #2;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkOutput(t, {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
                            EX_MEM_stall, MEM_WB_flush, hazard_state, stall_cnt, timeout_err}, e);
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        rst_n           = 1'b0;
        ID_EX_MemRd     = 1'b0;
        ID_EX_rd_idx    = 5'd0;
        IF_ID_rs1_idx   = 5'd0;
        IF_ID_rs2_idx   = 5'd0;
        IF_ID_use_rs2   = 1'b0;
        EX_branch_taken = 1'b0;
        dmem_req        = 1'b0;
        dmem_ready      = 1'b0;
        imem_ready      = 1'b1;
        perf_clr        = 1'b0;

        // Reset state. Random hazard inputs are applied while reset is held
        // to show that the controls stay quiet.
        applyStimulus("reset", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("reset_busy", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles("idle", 2);

        // Load-use on rs1, then the bubble cycle in LDUSE, then back to RUN.
        applyStimulus("lu_rs1", 1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idleCycles("lu_after", 2);

        // rd=x0 never creates a hazard, and rs2 only counts when it is used.
        applyStimulus("lu_x0", 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("lu_rs2_unused", 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("lu_rs2_used", 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idleCycles("lu_rs2_after", 1);
        applyStimulus("no_load", 1'b1, 1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Branch with a simultaneous load-use, then two slow fetches at the target.
        applyStimulus("br_lu", 1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("redir_wait", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("redir_wait", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles("redir_done", 2);

        // Clear the counter, then a 4-cycle data memory wait and its release.
        applyStimulus("perf_clr", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        memWaitCycles("memwait", 4, 1'b0);
        applyStimulus("mem_release", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idleCycles("mem_after", 1);

        // A branch held during a 3-cycle wait is flushed only on release.
        memWaitCycles("mw_branch", 3, 1'b1);
        applyStimulus("mw_branch_rel", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idleCycles("mw_branch_after", 2);

        // Timeout: 20 wait cycles, release, and the flag stays set.
        memWaitCycles("timeout", 20, 1'b0);
        applyStimulus("timeout_rel", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idleCycles("timeout_sticky", 2);

        // Reset pulse in the middle of a wait clears everything.
        memWaitCycles("pre_reset_wait", 3, 1'b0);
        applyStimulus("reset_midwait", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idleCycles("post_reset", 2);

        // Counter saturation from fetch stalls, then a clear during a stall.
        for (int i = 0; i < 20; i++)
            applyStimulus("fetch_stall", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("clr_in_stall", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("after_clr", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles("final_idle", 2);

        // Let the monitor drain the last vector. Anything left in the queue
        // means an expected output was never compared.
        @(negedge clk);
        #5;
        checkOutput("scoreboard_drain", 14'(expQ.size()), 14'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/riscv_hazard_ctrl.md
Name: riscv_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline, complementing the forwarding unit. It detects load-use hazards that forwarding cannot cover, branch/jump redirects resolved in EX, and instruction/data memory wait states. From these it drives per-stage stall and flush controls to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps a stall performance counter and a sticky data-memory timeout flag.

Parameters:
MEM_TIMEOUT, 16, consecutive dmem wait cycles after which timeout_err sets (range 1..255)
CNT_W, 32, width of stall_cnt

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset
ID_EX_MemRd  in  1  instruction in EX is a load
ID_EX_rd_idx  in  5  destination register of the EX instruction
IF_ID_rs1_idx  in  5  rs1 of the ID instruction
IF_ID_rs2_idx  in  5  rs2 of the ID instruction
IF_ID_use_rs2  in  1  ID instruction reads rs2 (R/S/B types)
EX_branch_taken  in  1  branch/jump in EX redirects the PC
dmem_req  in  1  MEM stage issuing a load/store
dmem_ready  in  1  data memory completes the request this cycle
imem_ready  in  1  instruction memory returns a valid fetch this cycle
perf_clr  in  1  synchronous clear of stall_cnt
pc_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF/ID
IF_ID_flush  out  1  load bubble into IF/ID
ID_EX_stall  out  1  hold ID/EX
ID_EX_flush  out  1  load bubble into ID/EX
EX_MEM_stall  out  1  hold EX/MEM
MEM_WB_flush  out  1  load bubble into MEM/WB
hazard_state  out  2  current FSM state
stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating
timeout_err  out  1  sticky dmem timeout

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low. While rst_n=0: state=RUN(0), every control output 0, stall_cnt=0, wait counter=0, timeout_err=0. Deasserting rst_n mid-operation resumes from RUN; no pending hazard is remembered.
- Control outputs are combinational in state and inputs (zero latency). hazard_state, the counters and timeout_err are registered.
- Condition definitions:
  - MW = dmem_req & ~dmem_ready
  - LU = ID_EX_MemRd & (ID_EX_rd_idx!=0) & ((ID_EX_rd_idx==IF_ID_rs1_idx) | (IF_ID_use_rs2 & ID_EX_rd_idx==IF_ID_rs2_idx))
- Priority, highest first: MW > EX_branch_taken > LU > ~imem_ready.
- MW in any state:
  - pc_stall, IF_ID_stall, ID_EX_stall and EX_MEM_stall are 1; MEM_WB_flush is 1; all other outputs 0.
  - Next state is MEMWAIT(2).
  - Because EX is frozen, a pending EX_branch_taken stays asserted and is serviced on the first cycle after MW drops.
- MEMWAIT:
  - The wait counter increments each MW cycle, saturating at MEM_TIMEOUT. When it reaches MEM_TIMEOUT, timeout_err sets; it clears only on reset.
  - There is no abort: the pipeline stays frozen until dmem_ready.
  - On the cycle dmem_ready=1, the stall drops in that same cycle, the wait counter clears, and the next state is chosen by priority from the remaining conditions (RUN if none).
- EX_branch_taken (no MW):
  - IF_ID_flush=1 and ID_EX_flush=1; pc_stall=0 so the PC loads the target.
  - The flush overrides LU in the same cycle.
  - Next state is REDIRECT(3).
- REDIRECT:
  - While imem_ready=0: pc_stall=1 and IF_ID_flush=1; stay in REDIRECT.
  - When imem_ready=1: no controls asserted; next state RUN.
  - A new EX_branch_taken in REDIRECT cannot occur (EX holds a bubble); if present, it is handled as above.
- LU (no MW, no branch):
  - pc_stall=1, IF_ID_stall=1, ID_EX_flush=1 for exactly one cycle.
  - Next state is LDUSE(1).
  - LDUSE returns to RUN unconditionally next cycle (or MEMWAIT if MW). LU is evaluated normally there: it is false because ID/EX now holds a bubble.
- RUN with ~imem_ready only: pc_stall=1 and IF_ID_flush=1; stay in RUN.
- stall_cnt:
  - +1 on each cycle with pc_stall=1; saturates at 2^CNT_W-1.
  - perf_clr=1 forces 0 next edge and wins over the increment.
- rd/rs index 0 never creates a load-use hazard.

Test Plan:
- Load-use: ID_EX_MemRd=1, ID_EX_rd_idx=5, IF_ID_rs1_idx=5 -> one cycle with pc_stall=IF_ID_stall=ID_EX_flush=1, hazard_state=1 the next cycle then 0, stall_cnt=1. Repeat with rd_idx=0 -> no stall. Repeat with match on rs2 and IF_ID_use_rs2=0 -> no stall.
- Branch plus LU same cycle: EX_branch_taken=1 together with an LU match -> IF_ID_flush=ID_EX_flush=1, pc_stall=0. With imem_ready=0 for 2 cycles -> pc_stall=IF_ID_flush=1 for 2 cycles in state 3, then state 0.
- Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles -> PC/IF_ID/ID_EX/EX_MEM stalls and MEM_WB_flush=1 for 4 cycles, state 2, stall_cnt=4. dmem_ready=1 -> all stalls drop in that cycle.
- MW plus branch: EX_branch_taken=1 held during a 3-cycle MW -> no flush during the wait; flush asserted on the cycle dmem_ready=1.
- Timeout: MEM_TIMEOUT=16 with 20 wait cycles -> timeout_err=1 from the 16th wait cycle, still 1 after release. rst_n pulse low mid-wait -> all outputs 0, state 0, timeout_err=0.
- Counter: CNT_W=4 with 20 stall cycles -> stall_cnt saturates at 15. perf_clr asserted during a stall -> 0 on the next edge.
